// File: rtl/data_memory_hs.sv
// data_memory_hs: handshaked RISC-V data memory with byte/half/word access,
// sign/zero extension, lane-masked stores, configurable latency and
// misalignment/illegal-size error reporting.
// Optional feature macro: DMEM_RESET_CLEAR_EN (zero the whole memory after reset).
module data_memory_hs #(
   parameter int ADDR_WIDTH = 16,
   parameter int MEM_DEPTH  = 2**(ADDR_WIDTH-2),
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IW = ADDR_WIDTH - 2;
   localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;
`ifdef DMEM_RESET_CLEAR_EN
   logic [IW-1:0]         clr_idx_q, clr_idx_d;
`endif

   logic [31:0]           mem_q [MEM_DEPTH];
   logic                  mem_we;
   logic [IW-1:0]         mem_widx;
   logic [31:0]           mem_wdata;

   // Access fields: live request while idle (LATENCY==1 resolves on the
   // accept edge), otherwise the latched copy.
   logic                  acc_write;
   logic [2:0]            acc_funct3;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [31:0]           acc_wdata;
   logic [IW-1:0]         acc_idx;
   logic [1:0]            acc_off;
   logic [31:0]           cur_word, shifted, wrep, bmask, merged, load_val;
   logic [3:0]            lane_mask;
   logic                  legal, enter_resp;

   // Decode size/alignment legality, load extension and the merged store word.
   always_comb begin
      acc_write  = (state_q == S_IDLE) ? req_write  : write_q;
      acc_funct3 = (state_q == S_IDLE) ? req_funct3 : funct3_q;
      acc_addr   = (state_q == S_IDLE) ? req_addr[ADDR_WIDTH-1:0] : addr_q;
      acc_wdata  = (state_q == S_IDLE) ? req_wdata  : wdata_q;
      acc_idx    = acc_addr[ADDR_WIDTH-1:2];
      acc_off    = acc_addr[1:0];
      cur_word   = mem_q[acc_idx];
      shifted    = cur_word >> {acc_off, 3'b000};
      legal      = 1'b0;
      lane_mask  = 4'b0000;
      load_val   = 32'h0;
      wrep       = acc_wdata;
      case (acc_funct3)
         3'b000: begin
            legal     = 1'b1;
            lane_mask = 4'b0001 << acc_off;
            load_val  = {{24{shifted[7]}}, shifted[7:0]};
            wrep      = {4{acc_wdata[7:0]}};
         end
         3'b001: begin
            legal     = !acc_off[0];
            lane_mask = acc_off[1] ? 4'b1100 : 4'b0011;
            load_val  = {{16{shifted[15]}}, shifted[15:0]};
            wrep      = {2{acc_wdata[15:0]}};
         end
         3'b010: begin
            legal     = (acc_off == 2'b00);
            lane_mask = 4'b1111;
            load_val  = cur_word;
         end
         3'b100: begin
            legal    = !acc_write;
            load_val = {24'h0, shifted[7:0]};
         end
         3'b101: begin
            legal    = !acc_write && !acc_off[0];
            load_val = {16'h0, shifted[15:0]};
         end
         default: legal = 1'b0;
      endcase
      for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{lane_mask[i]}};
      merged = (cur_word & ~bmask) | (wrep & bmask);
   end

   // Next-state, request latching, response capture and memory write strobe.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      mem_we     = 1'b0;
      mem_widx   = acc_idx;
      mem_wdata  = merged;
      enter_resp = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
      clr_idx_d  = clr_idx_q;
`endif
      case (state_q)
         S_CLEAR: begin
`ifdef DMEM_RESET_CLEAR_EN
            mem_we    = 1'b1;
            mem_widx  = clr_idx_q;
            mem_wdata = 32'h0;
            if (clr_idx_q == IW'(MEM_DEPTH - 1)) state_d = S_IDLE;
            else clr_idx_d = clr_idx_q + 1'b1;
`else
            state_d = S_IDLE;
`endif
         end
         S_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_addr[ADDR_WIDTH-1:0];
               wdata_d  = req_wdata;
               cnt_d    = CNT_INIT;
               if (LATENCY > 1) begin
                  state_d = S_WAIT;
               end else begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (enter_resp) begin
         err_d   = !legal;
         rdata_d = (legal && !acc_write) ? load_val : 32'h0;
         mem_we  = legal && acc_write;
      end
   end

   // State and response registers; reset drops any in-flight request.
   always_ff @(posedge clk) begin
      if (reset) begin
`ifdef DMEM_RESET_CLEAR_EN
         state_q   <= S_CLEAR;
         clr_idx_q <= '0;
`else
         state_q   <= S_IDLE;
`endif
         cnt_q     <= 4'd0;
         write_q   <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
      end else begin
`ifdef DMEM_RESET_CLEAR_EN
         clr_idx_q <= clr_idx_d;
`endif
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Memory array: one word write per cycle, suppressed during reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem_q[mem_widx] <= mem_wdata;
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed test-plan cases plus random accesses
// checked against an array-based memory model.
module tb_data_memory_hs;

   localparam int AW    = 8;
   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   int total = 0;
   int bad   = 0;
   logic [31:0] mdl [DEPTH];

   data_memory_hs #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: RISC-V load/store semantics on a plain word array.
   task automatic mdl_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] er, output logic ee);
      int idx, o;
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      idx = int'(a[AW-1:2]);
      o   = int'(a[1:0]);
      w   = mdl[idx];
      er  = 32'h0;
      ee  = (f3 == 3 || f3 >= 6) || (wr && f3 >= 4) ||
            ((f3 == 1 || f3 == 5) && o % 2 != 0) || (f3 == 2 && o != 0);
      if (!ee) begin
         if (wr) begin
            if (f3 == 0) w[8*o +: 8] = wd[7:0];
            else if (f3 == 1) w[8*o +: 16] = wd[15:0];
            else w = wd;
            mdl[idx] = w;
         end else begin
            b = w[8*o +: 8];
            h = (o < 2) ? w[15:0] : w[31:16];
            case (f3)
               3'd0: er = 32'($signed(b));
               3'd1: er = 32'($signed(h));
               3'd2: er = w;
               3'd4: er = {24'h0, b};
               default: er = {16'h0, h};
            endcase
         end
      end
   endtask

   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd);
      logic [31:0] er;
      logic        ee;
      int          n;
      n = 0;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (!req_ready) begin chk("ready_timeout", 32'(req_ready), 32'h1); rd = 32'hx; return; end
      mdl_access(wr, f3, a, wd, er, ee);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = $urandom; req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
      chk("latency", 32'(n), 32'(LAT));
      chk("err", 32'(resp_err), 32'(ee));
      chk("rdata", resp_rdata, er);
      rd = resp_rdata;
      @(negedge clk);
      chk("pulse_ready", {30'h0, resp_valid, req_ready}, 32'h1);
      chk("rdata_hold", resp_rdata, er);
   endtask

   task automatic apply_reset();
      int n;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rst_valid", 32'(resp_valid), 32'h0);
      chk("rst_err", 32'(resp_err), 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
`ifdef DMEM_RESET_CLEAR_EN
      chk("rst_ready", 32'(req_ready), 32'h0);
`else
      chk("rst_ready", 32'(req_ready), 32'h1);
`endif
      reset = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!req_ready && n < 200);
      chk("clear_cycles", 32'(n), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
      @(negedge clk);
`else
      n = 0;
`endif
   endtask

   logic [31:0] rd;
   int          n;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      apply_reset();
`ifdef DMEM_RESET_CLEAR_EN
      do_req(1'b0, 3'd2, 32'h0000_0024, 32'h0, rd);
      chk("clr_lw", rd, 32'h0);
`endif
      for (int i = 0; i < DEPTH; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom, rd);

      // Directed test-plan cases
      do_req(1'b1, 3'd2, 32'h10, 32'h8000_00FF, rd);
      do_req(1'b0, 3'd2, 32'h10, 32'h0, rd); chk("lw_10", rd, 32'h8000_00FF);
      do_req(1'b0, 3'd0, 32'h10, 32'h0, rd); chk("lb_10", rd, 32'hFFFF_FFFF);
      do_req(1'b0, 3'd4, 32'h10, 32'h0, rd); chk("lbu_10", rd, 32'h0000_00FF);
      do_req(1'b0, 3'd1, 32'h12, 32'h0, rd); chk("lh_12", rd, 32'hFFFF_8000);
      do_req(1'b0, 3'd5, 32'h12, 32'h0, rd); chk("lhu_12", rd, 32'h0000_8000);
      do_req(1'b1, 3'd2, 32'h10, 32'h1122_3344, rd);
      do_req(1'b1, 3'd0, 32'h11, 32'h0000_00AB, rd);
      do_req(1'b0, 3'd2, 32'h10, 32'h0, rd); chk("sb_merge", rd, 32'h1122_AB44);
      do_req(1'b1, 3'd1, 32'h12, 32'h0000_BEEF, rd);
      do_req(1'b0, 3'd2, 32'h10, 32'h0, rd); chk("sh_merge", rd, 32'hBEEF_AB44);
      do_req(1'b1, 3'd2, 32'h13, 32'hFFFF_FFFF, rd); chk("sw_mis_err", 32'(resp_err), 32'h1);
      do_req(1'b0, 3'd1, 32'h11, 32'h0, rd); chk("lh_mis_err", 32'(resp_err), 32'h1);
      do_req(1'b0, 3'd7, 32'h10, 32'h0, rd); chk("f7_err", 32'(resp_err), 32'h1);
      do_req(1'b1, 3'd4, 32'h10, 32'h0, rd); chk("sbu_err", 32'(resp_err), 32'h1);
      do_req(1'b0, 3'd2, 32'h10, 32'h0, rd); chk("unchanged", rd, 32'hBEEF_AB44);

      // Random accesses, including ignored upper address bits
      for (int i = 0; i < 300; i++)
         do_req(1'($urandom), 3'($urandom), $urandom, $urandom, rd);

      // Reset while a store sits in WAIT
      do_req(1'b1, 3'd2, 32'h20, 32'h0000_0055, rd);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1; req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rstw_valid", 32'(resp_valid), 32'h0);
      chk("rstw_rdata", resp_rdata, 32'h0);
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (resp_valid) n++; end
      chk("rstw_noresp", 32'(n), 32'h0);
`ifdef DMEM_RESET_CLEAR_EN
      n = 0;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
      do_req(1'b0, 3'd2, 32'h20, 32'h0, rd); chk("rstw_lw", rd, 32'h0);
`else
      do_req(1'b0, 3'd2, 32'h20, 32'h0, rd); chk("rstw_lw", rd, 32'h0000_0055);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
